// File: rtl/pio_share_if.sv
// pio_share_if: requester inputs and grant/bus outputs of the shared PIO arbiter
interface pio_share_if;
   logic [2:0] req, last, gnt;
   logic [7:0] din0, din1, din2, fpga_pio;
   logic pttl, pio_valid, busy, timeout;
   modport master(output req, last, din0, din1, din2, pttl, input gnt, fpga_pio, pio_valid, busy, timeout);
   modport slave(input req, last, din0, din1, din2, pttl, output gnt, fpga_pio, pio_valid, busy, timeout);
endinterface

// File: rtl/pio_share_arb.sv
// pio_share_arb: round-robin arbiter granting one of three requesters a bounded burst on a shared PIO bus
module pio_share_arb #(
   parameter int MAX_BEATS = 8,
   parameter int GAP_CYC = 2
) (
   input logic clk,
   input logic rst,
   pio_share_if.slave bus
);
   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
   localparam logic [3:0] MB = 4'(MAX_BEATS);
   localparam logic [2:0] GL = 3'(GAP_CYC == 0 ? 0 : GAP_CYC - 1);
   state_t state, state_n;
   logic [1:0] rr, rr_n, gi, off, idx;
   logic [2:0] sum, rot, pick, gnt, gnt_n, gc, gc_n;
   logic [3:0] bc, bc_n, bc_inc;
   logic [7:0] pio, pio_n, din_g;
   logic pv, pv_n, to, to_n, req_g, last_g, beat, done;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         rr <= '0;
         bc <= '0;
         gc <= '0;
         gnt <= '0;
         pio <= '0;
         pv <= 1'b0;
         to <= 1'b0;
      end else begin
         state <= state_n;
         rr <= rr_n;
         bc <= bc_n;
         gc <= gc_n;
         gnt <= gnt_n;
         pio <= pio_n;
         pv <= pv_n;
         to <= to_n;
      end
   // rotate req so bit 0 is the requester at the round-robin pointer
   always_comb begin
      rot = rr == 2'd0 ? bus.req : rr == 2'd1 ? {bus.req[0], bus.req[2], bus.req[1]} : {bus.req[1], bus.req[0], bus.req[2]};
      off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : 2'd2;
      sum = {1'b0, rr} + {1'b0, off};
      idx = sum >= 3'd3 ? 2'(sum - 3'd3) : sum[1:0];
      pick = 3'b001 << idx;
      gi = gnt[1] ? 2'd1 : gnt[2] ? 2'd2 : 2'd0;
      req_g = |(bus.req & gnt);
      last_g = |(bus.last & gnt);
      din_g = gnt[1] ? bus.din1 : gnt[2] ? bus.din2 : bus.din0;
      bc_inc = bc + 4'd1;
      beat = state == XFER && req_g && bus.pttl;
      done = state == XFER && (!req_g || (beat && (last_g || bc_inc == MB)));
      state_n = state;
      rr_n = rr;
      bc_n = beat ? bc_inc : bc;
      gc_n = gc;
      gnt_n = gnt;
      pio_n = beat ? din_g : pio;
      pv_n = beat;
      to_n = beat && !last_g && bc_inc == MB;
      if (state == IDLE && bus.pttl && |bus.req) begin
         gnt_n = pick;
         state_n = XFER;
      end
      if (done) begin
         gnt_n = '0;
         bc_n = '0;
         gc_n = '0;
         rr_n = gi == 2'd2 ? 2'd0 : gi + 2'd1;
         state_n = GAP_CYC == 0 ? IDLE : GAP;
      end
      if (state == GAP) begin
         gc_n = gc == GL ? 3'd0 : gc + 3'd1;
         state_n = gc == GL ? IDLE : GAP;
      end
   end
   assign bus.gnt = gnt;
   assign bus.fpga_pio = pio;
   assign bus.pio_valid = pv;
   assign bus.busy = state != IDLE;
   assign bus.timeout = to;
endmodule

// File: tb/tb_pio_share_arb.sv
// tb_pio_share_arb: directed scenarios with a beat scoreboard checked by an independent monitor
module tb_pio_share_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   pio_share_if b();
   pio_share_arb #(.MAX_BEATS(8), .GAP_CYC(2)) dut (.clk(clk), .rst(rst), .bus(b));
   always #5 clk = ~clk;
   logic [7:0] expq[$];
   logic [7:0] e;
   int mon_cmp = 0, mon_err = 0, dir_cmp = 0, dir_err = 0, to_cnt = 0;
   always @(negedge clk)
      if (rst) begin
         if (b.timeout) to_cnt++;
         if (b.pio_valid) begin
            mon_cmp++;
            if (expq.size() == 0) begin
               mon_err++;
               $display("FAIL beat: got %02h while no beat was expected", b.fpga_pio);
            end else begin
               e = expq.pop_front();
               if (b.fpga_pio !== e) begin
                  mon_err++;
                  $display("FAIL beat: got %02h expected %02h", b.fpga_pio, e);
               end
            end
         end
      end
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      dir_cmp++;
      if (act !== exp) begin
         dir_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_gnt(input logic [2:0] g, input string nm);
      int i = 0;
      do begin tick(); i++; end while (b.gnt == 3'b000 && i < 12);
      check(nm, 32'(b.gnt), 32'(g));
   endtask
   task automatic wait_idle;
      int i = 0;
      while (b.busy && i < 20) begin tick(); i++; end
      check("idle", 32'(b.busy), 0);
   endtask
   task automatic set_din(input int g, input logic [7:0] v);
      if (g == 0) b.din0 = v;
      else if (g == 1) b.din1 = v;
      else b.din2 = v;
   endtask
   function automatic int gidx(input logic [2:0] g);
      return g[1] ? 1 : g[2] ? 2 : 0;
   endfunction
   initial begin
      logic [2:0] seq[$];
      int gaps[$];
      int bt, zc, g;
      logic [7:0] d;
      b.req = 3'b000; b.last = 3'b000; b.pttl = 1'b0;
      b.din0 = 8'h00; b.din1 = 8'h00; b.din2 = 8'h00;
      #1 rst = 1'b0;
      #2;
      check("rst_gnt", 32'(b.gnt), 0);
      check("rst_pio", 32'(b.fpga_pio), 0);
      check("rst_valid", 32'(b.pio_valid), 0);
      check("rst_busy", 32'(b.busy), 0);
      check("rst_timeout", 32'(b.timeout), 0);
      tick();
      tick();
      rst = 1'b1;
      // three requesters, two beats each, last on beat 2; non-granted din/last are noise
      b.req = 3'b111; b.pttl = 1'b1; bt = 0; zc = 0;
      repeat (24) begin
         tick();
         if (b.gnt != 3'b000) begin
            g = gidx(b.gnt);
            if (bt == 0) begin
               seq.push_back(b.gnt);
               if (seq.size() > 1) gaps.push_back(zc);
               zc = 0;
            end
            d = 8'(16 * (g + 1) + bt);
            for (int j = 0; j < 3; j++) set_din(j, j == g ? d : 8'($urandom));
            b.last = bt == 1 ? b.gnt : 3'($urandom) & ~b.gnt;
            expq.push_back(d);
            bt = bt == 1 ? 0 : 1;
         end else begin
            b.last = 3'b000;
            if (b.busy) zc++;
            if (seq.size() == 3) b.req = 3'b000;
         end
      end
      check("rr_seq_len", 32'(seq.size()), 3);
      if (seq.size() == 3) begin
         check("rr_seq0", 32'(seq[0]), 32'h1);
         check("rr_seq1", 32'(seq[1]), 32'h2);
         check("rr_seq2", 32'(seq[2]), 32'h4);
      end
      check("gap_len", 32'(gaps.size()), 2);
      foreach (gaps[i]) check("gap_cycles", 32'(gaps[i]), 2);
      wait_idle();
      // requester 1 runs to MAX_BEATS without last
      b.req = 3'b010; b.din1 = 8'hA5; b.last = 3'b000;
      wait_gnt(3'b010, "to_gnt");
      for (int k = 0; k < 8; k++) begin
         expq.push_back(8'hA5);
         tick();
      end
      check("to_end_gnt", 32'(b.gnt), 0);
      check("to_pulse", 32'(b.timeout), 1);
      b.req = 3'b000;
      tick();
      check("to_single", 32'(b.timeout), 0);
      wait_idle();
      b.req = 3'b111;
      wait_gnt(3'b100, "rr_after_to");
      b.req = 3'b000;
      tick();
      // stall with pttl low mid-burst
      b.req = 3'b001; b.din0 = 8'h31;
      wait_gnt(3'b001, "stall_gnt");
      expq.push_back(8'h31);
      tick();
      b.din0 = 8'h32;
      expq.push_back(8'h32);
      tick();
      b.pttl = 1'b0; b.din0 = 8'h99;
      repeat (3) begin
         tick();
         check("stall_valid", 32'(b.pio_valid), 0);
         check("stall_hold", 32'(b.fpga_pio), 32'h32);
         check("stall_gnt_hold", 32'(b.gnt), 32'h1);
      end
      b.pttl = 1'b1; b.din0 = 8'h33; b.last = 3'b001;
      expq.push_back(8'h33);
      tick();
      check("stall_end", 32'(b.gnt), 0);
      b.last = 3'b000; b.req = 3'b000;
      tick();
      check("retain_pio", 32'(b.fpga_pio), 32'h33);
      check("retain_valid", 32'(b.pio_valid), 0);
      // requester 2 drops req after one beat
      b.req = 3'b100; b.din2 = 8'hC1;
      wait_gnt(3'b100, "drop_gnt");
      expq.push_back(8'hC1);
      tick();
      b.req = 3'b000;
      tick();
      check("drop_end", 32'(b.gnt), 0);
      check("drop_no_to", 32'(b.timeout), 0);
      b.req = 3'b111;
      wait_gnt(3'b001, "next_from_r0");
      b.req = 3'b000;
      tick();
      // async reset during beat 4
      b.req = 3'b001;
      wait_gnt(3'b001, "rst_burst_gnt");
      for (int k = 1; k <= 3; k++) begin
         b.din0 = 8'(8'h40 + k);
         expq.push_back(b.din0);
         tick();
      end
      b.din0 = 8'h44;
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("arst_gnt", 32'(b.gnt), 0);
      check("arst_pio", 32'(b.fpga_pio), 0);
      check("arst_valid", 32'(b.pio_valid), 0);
      check("arst_busy", 32'(b.busy), 0);
      tick();
      rst = 1'b1; b.req = 3'b110;
      tick();
      check("post_reset_first", 32'(b.gnt), 32'h2);
      b.req = 3'b000;
      tick();
      // last coincides with beat MAX_BEATS
      b.req = 3'b100;
      wait_gnt(3'b100, "coin_gnt");
      for (int k = 1; k <= 8; k++) begin
         b.din2 = 8'(8'h60 + k);
         b.last = k == 8 ? 3'b100 : 3'b000;
         expq.push_back(b.din2);
         tick();
      end
      check("coin_end", 32'(b.gnt), 0);
      check("coin_no_to", 32'(b.timeout), 0);
      b.req = 3'b000; b.last = 3'b000;
      tick();
      check("coin_no_to2", 32'(b.timeout), 0);
      tick();
      check("queue_drained", 32'(expq.size()), 0);
      check("to_count", 32'(to_cnt), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", dir_cmp + mon_cmp, dir_err + mon_err);
      $finish;
   end
endmodule
